// File: rtl/mult_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_acc_pkg
//  Brief    : Shared types and constants for the multiply-accumulate result
//             accumulator: FSM state encoding, default widths and the signed
//             extremes of the default-width accumulator.
//  Config   : MULT_ACC_SAT_EN (see mult_acc_addsat / mult_result_accumulator)
//  Revision : 1.0 - initial release
// ============================================================================
package mult_acc_pkg;

    // Default widths: 64-bit products from the 32x32 multiplier, widened sum.
    localparam int DEF_PROD_W = 64;
    localparam int DEF_ACC_W  = 72;
    localparam int DEF_CNT_W  = 8;

    // Run-control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Signed extremes of the default-width accumulator.
    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage : mult_acc_pkg
`default_nettype wire

// File: rtl/mult_acc_addsat.sv
`default_nettype none
// ============================================================================
//  Module   : mult_acc_addsat
//  Brief    : Combinational ACC_W-bit signed adder with signed-overflow flag.
//             With MULT_ACC_SAT_EN defined the result clamps to the signed
//             extreme in the direction of the operands' common sign;
//             otherwise the result wraps modulo 2^ACC_W.
//  Config   : MULT_ACC_SAT_EN
//  Revision : 1.0 - initial release
// ============================================================================
module mult_acc_addsat
    import mult_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] raw_sum;

    // Two's-complement add; overflow when like-signed operands yield an
    // unlike-signed result.
    always_comb begin
        raw_sum = a + b;
        ovf     = (a[ACC_W-1] == b[ACC_W-1]) && (raw_sum[ACC_W-1] != a[ACC_W-1]);
`ifdef MULT_ACC_SAT_EN
        if (ovf) begin
            sum = a[ACC_W-1] ? C_MIN : C_MAX;
        end else begin
            sum = raw_sum;
        end
`else
        sum = raw_sum;
`endif
    end

endmodule : mult_acc_addsat
`default_nettype wire

// File: rtl/mult_result_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mult_result_accumulator
//  Brief    : Sums a programmed number of signed products received over a
//             valid/ready handshake into a widened accumulator and presents
//             the final sum (plus sticky overflow) on a held output
//             handshake. Forms the accumulate half of a MAC/dot-product path.
//  Config   : MULT_ACC_SAT_EN - clamp the accumulator on signed overflow
//             instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_result_accumulator
    import mult_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic             ovf_q,   ovf_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    // Sign-extend the product; replication count stays >= 1 even when
    // ACC_W equals PROD_W.
    assign prod_ext = {{(ACC_W-PROD_W+1){prod[PROD_W-1]}}, prod[PROD_W-2:0]};

    mult_acc_addsat #(
        .ACC_W (ACC_W)
    ) u_addsat (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Next-state, counter, accumulator and sticky-overflow update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCUM: begin
                if (prod_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Sum and overflow are held; start is ignored here.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset abandons any run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake/status outputs decode the state register only.
    assign prod_ready = (state_q == ST_ACCUM);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign acc_out    = acc_q;
    assign overflow   = ovf_q;

endmodule : mult_result_accumulator
`default_nettype wire

// File: tb/tb_mult_result_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_result_accumulator
//  Brief    : Directed self-checking bench for mult_result_accumulator.
//             A default-width instance covers the handshake/timing cases; a
//             64-bit-accumulator instance makes signed overflow reachable.
//  Config   : MULT_ACC_SAT_EN selects the expected overflow result.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_result_accumulator;

    logic        clk = 1'b0;
    logic        rst;

    // Default-width instance
    logic        start;
    logic [7:0]  len;
    logic        prod_valid;
    logic [63:0] prod;
    logic        prod_ready;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] acc_out;
    logic        overflow;
    logic        busy;

    // 64-bit accumulator instance
    logic        s_start;
    logic [7:0]  s_len;
    logic        s_prod_valid;
    logic [63:0] s_prod;
    logic        s_prod_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [63:0] s_acc_out;
    logic        s_overflow;
    logic        s_busy;

    int n_vec = 0;
    int n_err = 0;

    logic signed [63:0] m_op, q_op;
    logic [71:0]        exp_sum;
    int                 cycles;

    always #5 clk = ~clk;

    mult_result_accumulator u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_ready (prod_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_out    (acc_out),
        .overflow   (overflow),
        .busy       (busy)
    );

    mult_result_accumulator #(
        .PROD_W (64),
        .ACC_W  (64),
        .CNT_W  (8)
    ) u_dut64 (
        .clk        (clk),
        .rst        (rst),
        .start      (s_start),
        .len        (s_len),
        .prod_valid (s_prod_valid),
        .prod       (s_prod),
        .prod_ready (s_prod_ready),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .acc_out    (s_acc_out),
        .overflow   (s_overflow),
        .busy       (s_busy)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; everything is sampled and driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; out_ready = 1'b0;
        s_start = 1'b0; s_len = '0; s_prod_valid = 1'b0; s_prod = '0; s_out_ready = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_prod_ready", prod_ready, 0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_busy",       busy,       0);
        check("rst_acc_out",    acc_out,    0);
        check("rst_overflow",   overflow,   0);
        rst = 1'b0;
        tick();

        // Back-to-back run of 3 products
        exp_sum = 72'd1086626725895;   // 7 - 3*2^32 + 2^40
        start = 1'b1; len = 8'd3;
        tick(); cycles = 1;
        start = 1'b0;
        check("a_busy",       busy,       1);
        check("a_prod_ready", prod_ready, 1);
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1'b1;
            prod = (i == 0) ? 64'd7 : (i == 1) ? -64'd12884901888 : 64'd1099511627776;
            if (i == 2) check("a_not_done_yet", out_valid, 0);
            tick(); cycles++;
        end
        prod_valid = 1'b0;
        check("a_out_valid",  out_valid, 1);
        check("a_latency",    cycles,    4);
        check("a_sum",        acc_out,   exp_sum);
        check("a_overflow",   overflow,  0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a_ov_drop",    out_valid, 0);
        check("a_idle",       busy,      0);

        // Same run with stalls on input and output
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1'b1;
            prod = (i == 0) ? 64'd7 : (i == 1) ? -64'd12884901888 : 64'd1099511627776;
            tick();
            prod_valid = 1'b0;
            if (i < 2) begin
                tick(); tick();
                check("b_stall_ready", prod_ready, 1);
            end
        end
        check("b_out_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check("b_hold_sum", acc_out,   exp_sum);
            check("b_hold_ov",  out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b_ov_drop", out_valid, 0);

        // len = 0, then start ignored in DONE and on the handshake cycle
        start = 1'b1; len = 8'd0;
        tick();
        check("c_out_valid", out_valid, 1);
        check("c_sum",       acc_out,   0);
        len = 8'd5;
        tick();
        check("c_done_hold", out_valid, 1);
        out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("c_start_ign", busy, 0);

        // start during ACCUM is ignored (no reload of len)
        start = 1'b1; len = 8'd2;
        tick();
        len = 8'd7;
        prod_valid = 1'b1; prod = 64'd10;
        tick();
        prod = 64'd20;
        tick();
        start = 1'b0; prod_valid = 1'b0;
        check("d_done", out_valid, 1);
        check("d_sum",  acc_out,   72'd30);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset after 2 of 4 products
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod = 64'd100;
        tick();
        prod = 64'd200;
        tick();
        prod_valid = 1'b0;
        check("e_mid_sum", acc_out, 72'd300);
        rst = 1'b1;
        #2;
        check("e_rst_busy", busy,     0);
        check("e_rst_acc",  acc_out,  0);
        check("e_rst_ovf",  overflow, 0);
        tick();
        rst = 1'b0;
        check("e_rst_ready", prod_ready, 0);
        tick();
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod = 64'd5;
        tick();
        prod_valid = 1'b0;
        check("e_after_sum", acc_out, 72'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Products from the 32x32 multiplier: (-3*4) + (5*6)
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        prod_valid = 1'b1;
        m_op = -64'sd3; q_op = 64'sd4;
        prod = m_op * q_op;
        tick();
        m_op = 64'sd5; q_op = 64'sd6;
        prod = m_op * q_op;
        tick();
        prod_valid = 1'b0;
        check("f_mac_sum", acc_out, 72'd18);
        check("f_mac_ovf", overflow, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Signed overflow with a 64-bit accumulator: (2^63-1) + 1
        s_start = 1'b1; s_len = 8'd2;
        tick();
        s_start = 1'b0;
        s_prod_valid = 1'b1; s_prod = 64'h7FFF_FFFF_FFFF_FFFF;
        tick();
        s_prod = 64'd1;
        tick();
        s_prod_valid = 1'b0;
        check("g_ovf_valid", s_out_valid, 1);
`ifdef MULT_ACC_SAT_EN
        check("g_ovf_sum", s_acc_out, 72'h00_7FFF_FFFF_FFFF_FFFF);
`else
        check("g_ovf_sum", s_acc_out, 72'h00_8000_0000_0000_0000);
`endif
        check("g_ovf_flag", s_overflow, 1);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;

        // Overflow clears on the next start
        s_start = 1'b1; s_len = 8'd1;
        tick();
        s_start = 1'b0;
        s_prod_valid = 1'b1; s_prod = 64'd1;
        tick();
        s_prod_valid = 1'b0;
        check("g_ovf_clear", s_overflow, 0);
        check("g_clear_sum", s_acc_out,  72'd1);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mult_result_accumulator
`default_nettype wire
